stream_tx: RTL
==============

STREAM_TX -- requirements
Module: stream_tx

Interface
REQ-001 SHALL have parameter WIDTH, default 256, data beat width in bits.
REQ-002 SHALL have parameter KEEP_W, default WIDTH/8 (32), byte-enable width.
REQ-003 SHALL have clk  input  1  sole clock; all logic on its rising edge.
REQ-004 SHALL have rst  input  1  reset, asynchronous and active-high.
REQ-005 SHALL have fifo_rd_en  output  1  pop request to the upstream first-word-fall-through FIFO.
REQ-006 SHALL have fifo_rd_data  input  WIDTH  FIFO head data, valid while fifo_empty is low.
REQ-007 SHALL have fifo_rd_keep  input  KEEP_W  FIFO head byte enables.
REQ-008 SHALL have fifo_rd_last  input  1  FIFO head end-of-packet flag.
REQ-009 SHALL have fifo_empty  input  1  FIFO empty flag.
REQ-010 SHALL have m_tvalid  output  1  and m_tready  input  1, the AXI-Stream master handshake.
REQ-011 SHALL have m_tdata  output  WIDTH,  m_tkeep  output  KEEP_W,  m_tlast  output  1.
REQ-012 SHALL have in_pkt  output  1  high while a packet is started but not yet ended.
REQ-013 SHALL have pkt_len  output  16  byte length of the last completed packet.
REQ-014 SHALL have len_valid  output  1  one-cycle pulse when pkt_len updates.
REQ-015 SHALL have pkt_count  output  32  and err_keep  output  1 (one-cycle pulse) and err_count  output  16.

Function
REQ-016 SHALL hold a 2-entry output buffer (slot0 drives m_t*, slot1 is skid) with occupancy occ in 0..2.
REQ-017 SHALL drive fifo_rd_en = !fifo_empty && (occ != 2), a function of registered state and fifo_empty only, with no path from m_tready.
REQ-018 SHALL capture fifo_rd_data/keep/last on any cycle where fifo_rd_en is high; the captured word appears at the output no earlier than the next cycle.
REQ-019 SHALL drive m_tvalid = (occ != 0); a handshake occurs when m_tvalid && m_tready.
REQ-020 SHALL hold m_tdata/m_tkeep/m_tlast stable while m_tvalid is high and m_tready is low.
REQ-021 SHALL preserve FIFO order exactly: no beat dropped, duplicated or reordered.
REQ-022 On a simultaneous pop and handshake, slot0 SHALL take slot1 if occ==2, else the popped word; occ then stays unchanged.
REQ-023 SHALL sustain one beat per cycle when m_tready is held high and the FIFO is never empty.
REQ-024 SHALL accumulate popcount(m_tkeep) per handshake into a 16-bit accumulator that saturates at 65535.
REQ-025 On a handshake with m_tlast=1: pkt_len <= accumulated+popcount (saturated); len_valid pulses; pkt_count increments (wraps at 2^32); accumulator clears.
REQ-026 SHALL use packet FSM states IDLE and IN_PKT: IDLE->IN_PKT on a non-last handshake; IN_PKT->IDLE on a last handshake; a single-beat packet stays in IDLE; in_pkt = (state==IN_PKT).
REQ-027 SHALL flag a keep error at handshake when a non-last beat has keep != all-ones, or a last beat has keep == 0 or keep not contiguous from bit 0.
REQ-028 On a keep error: err_keep pulses one cycle; err_count increments, saturating at 65535; the beat is still forwarded unchanged.

Reset
REQ-029 While rst is high: m_tvalid, m_tdata, m_tkeep, m_tlast, fifo_rd_en, in_pkt, len_valid, err_keep, pkt_len, pkt_count and err_count SHALL all be 0; occ and the accumulator SHALL be 0; state SHALL be IDLE.
REQ-030 Reset asserted mid-packet SHALL discard buffered beats and the partial length; no FIFO pop occurs while rst is high.

Structure
REQ-031 Shared package stream_pkg SHALL hold WIDTH/KEEP_W defaults, the beat struct typedef (data, keep, last) and the tx_state_t enum (IDLE, IN_PKT).
REQ-032 One combinational sub-module, keep_check, SHALL compute popcount and contiguity of a keep vector.

Verification
REQ-033 Single-beat packet, keep=0x0000_000F, last=1, m_tready=1 -> m_tvalid the cycle after the pop; pkt_len=4; len_valid pulses; pkt_count=1; in_pkt stays 0.
REQ-034 Three-beat packet, keeps FFFFFFFF, FFFFFFFF, 0000FFFF -> pkt_len=80; in_pkt high from beat1 through beat3 handshake; err_count=0.
REQ-035 Backpressure: 5 beats queued, m_tready low for 10 cycles -> occ reaches 2, fifo_rd_en low, output held stable; after release all 5 beats emitted in order.
REQ-036 Keep errors: non-last keep=0x7FFFFFFF, then last keep=0x0000000A -> err_keep pulses twice; err_count=2; both beats forwarded.
REQ-037 rst asserted with occ=2 mid-packet -> all outputs 0 immediately; after release the next packet reports the correct pkt_len with no stale beats.

Source files
------------

// File: rtl/stream_pkg.sv
// Shared definitions for the stream transmit path: default beat geometry,
// counter widths, the beat payload struct and the packet FSM state type.
package stream_pkg;

  localparam int unsigned WIDTH_DEF  = 256;
  localparam int unsigned KEEP_W_DEF = WIDTH_DEF / 8;
  localparam int unsigned LEN_W      = 16;
  localparam int unsigned CNT_W      = 32;
  localparam int unsigned ERR_W      = 16;
  localparam int unsigned OCC_W      = 2;

  typedef struct packed {
    logic [WIDTH_DEF-1:0]  data;
    logic [KEEP_W_DEF-1:0] keep;
    logic                  last;
  } beat_t;

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    IN_PKT = 1'b1
  } tx_state_t;

endpackage

// File: rtl/keep_check.sv
// Combinational byte-enable analysis.
// Ports:
//   keep   - byte-enable vector of the current output beat
//   count  - number of set bits in keep
//   contig - keep is non-zero and its set bits run contiguously from bit 0
module keep_check
  import stream_pkg::*;
#(
  parameter int unsigned KEEP_W = KEEP_W_DEF
) (
  input  logic [KEEP_W-1:0] keep,
  output logic [LEN_W-1:0]  count,
  output logic              contig
);

  // Population count
  always_comb begin
    count = '0;
    for (int unsigned i = 0; i < KEEP_W; i++) begin
      count = count + LEN_W'(keep[i]);
    end
  end

  // A 0..01..1 pattern plus one has no bit in common with itself
  assign contig = (keep != '0) && ((keep & (keep + KEEP_W'(1))) == '0);

endmodule

// File: rtl/stream_tx.sv
// Transmit stage: pops beats from a first-word-fall-through FIFO into a
// two-entry skid buffer and presents them as an AXI-Stream master, while
// tracking packet length, packet count and byte-enable errors.
// Ports:
//   clk, rst                       - clock, async active-high reset
//   fifo_rd_en / fifo_rd_*         - FIFO pop request and head beat
//   fifo_empty                     - FIFO empty flag
//   m_tvalid/m_tready/m_t*         - AXI-Stream master
//   in_pkt                         - a packet has started but not ended
//   pkt_len, len_valid             - byte length of last packet + update pulse
//   pkt_count                      - completed packets (wrapping)
//   err_keep, err_count            - keep error pulse + saturating count
module stream_tx
  import stream_pkg::*;
#(
  parameter int unsigned WIDTH  = WIDTH_DEF,
  parameter int unsigned KEEP_W = WIDTH / 8
) (
  input  logic              clk,
  input  logic              rst,
  output logic              fifo_rd_en,
  input  logic [WIDTH-1:0]  fifo_rd_data,
  input  logic [KEEP_W-1:0] fifo_rd_keep,
  input  logic              fifo_rd_last,
  input  logic              fifo_empty,
  output logic              m_tvalid,
  input  logic              m_tready,
  output logic [WIDTH-1:0]  m_tdata,
  output logic [KEEP_W-1:0] m_tkeep,
  output logic              m_tlast,
  output logic              in_pkt,
  output logic [LEN_W-1:0]  pkt_len,
  output logic              len_valid,
  output logic [CNT_W-1:0]  pkt_count,
  output logic              err_keep,
  output logic [ERR_W-1:0]  err_count
);

  localparam logic [OCC_W-1:0] OCC_EMPTY = OCC_W'(0);
  localparam logic [OCC_W-1:0] OCC_FULL  = OCC_W'(2);
  localparam logic [LEN_W-1:0] LEN_MAX   = '1;
  localparam logic [ERR_W-1:0] ERR_MAX   = '1;

  logic [OCC_W-1:0]  occ;
  logic [WIDTH-1:0]  s0_data, s1_data;
  logic [KEEP_W-1:0] s0_keep, s1_keep;
  logic              s0_last, s1_last;
  logic              pop_c, hs_c;
  tx_state_t         state, state_nxt;
  logic [LEN_W-1:0]  acc, kc_count, acc_sat_c;
  logic [LEN_W:0]    acc_sum_c;
  logic              kc_contig, keep_err_c;

  // Pop depends only on registered occupancy and the FIFO flag; never on m_tready
  assign pop_c      = !rst && !fifo_empty && (occ != OCC_FULL);
  assign fifo_rd_en = pop_c;
  assign m_tvalid   = (occ != OCC_EMPTY);
  assign hs_c       = m_tvalid && m_tready;
  assign m_tdata    = s0_data;
  assign m_tkeep    = s0_keep;
  assign m_tlast    = s0_last;

  // Skid buffer: slot0 drives the bus, slot1 absorbs the in-flight pop
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      occ     <= OCC_EMPTY;
      s0_data <= '0;
      s0_keep <= '0;
      s0_last <= 1'b0;
      s1_data <= '0;
      s1_keep <= '0;
      s1_last <= 1'b0;
    end else if (pop_c && hs_c) begin
      // A pop never coincides with a full buffer, so slot0 takes the popped word
      s0_data <= fifo_rd_data;
      s0_keep <= fifo_rd_keep;
      s0_last <= fifo_rd_last;
    end else if (hs_c) begin
      s0_data <= s1_data;
      s0_keep <= s1_keep;
      s0_last <= s1_last;
      occ     <= occ - OCC_W'(1);
    end else if (pop_c) begin
      if (occ == OCC_EMPTY) begin
        s0_data <= fifo_rd_data;
        s0_keep <= fifo_rd_keep;
        s0_last <= fifo_rd_last;
      end else begin
        s1_data <= fifo_rd_data;
        s1_keep <= fifo_rd_keep;
        s1_last <= fifo_rd_last;
      end
      occ <= occ + OCC_W'(1);
    end
  end

  keep_check #(.KEEP_W(KEEP_W)) u_keep_check (
    .keep   (s0_keep),
    .count  (kc_count),
    .contig (kc_contig)
  );

  assign acc_sum_c  = {1'b0, acc} + {1'b0, kc_count};
  assign acc_sat_c  = acc_sum_c[LEN_W] ? LEN_MAX : acc_sum_c[LEN_W-1:0];
  assign keep_err_c = s0_last ? !kc_contig : (s0_keep != '1);

  // Length accumulation, packet count and keep-error statistics
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc       <= '0;
      pkt_len   <= '0;
      len_valid <= 1'b0;
      pkt_count <= '0;
      err_keep  <= 1'b0;
      err_count <= '0;
    end else begin
      len_valid <= hs_c && s0_last;
      err_keep  <= hs_c && keep_err_c;
      if (hs_c) begin
        if (s0_last) begin
          pkt_len   <= acc_sat_c;
          pkt_count <= pkt_count + CNT_W'(1);
          acc       <= '0;
        end else begin
          acc <= acc_sat_c;
        end
        if (keep_err_c && (err_count != ERR_MAX)) begin
          err_count <= err_count + ERR_W'(1);
        end
      end
    end
  end

  // Packet FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Packet FSM next state
  always_comb begin
    state_nxt = state;
    if (hs_c) begin
      state_nxt = s0_last ? IDLE : IN_PKT;
    end
  end

  assign in_pkt = (state == IN_PKT);

endmodule
